led_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It owns a double-buffered digit store and walks a digit index at a programmable rate. Each cycle it presents one hex nibble to the shared hex-to-segment decoder and registers the returned code onto the segment bus. It inserts the decimal point and drives the active-low digit commons with a dead-time gap between digits. It sits between the register/UART side, which writes display values, and the pad-level segment/common outputs.

---
 rtl/led_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module led_scan_ctrl #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [4*DIGITS-1:0] wr_data,
    input  logic [DIGITS-1:0]   wr_dp,
    input  logic                blank,
    output logic [3:0]          dec_num,
    input  logic [7:0]          dec_seg,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   com,
    output logic                upd_pend,
    output logic                frame_tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1'b1);
    localparam logic [DIGITS-1:0] COM_OFF  = {DIGITS{1'b1}};
    localparam logic [DIGITS-1:0] COM_ONE  = DIGITS'(1'b1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_disp;
    logic [DIGITS-1:0]   r_dp;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic                r_upd_pend;
    logic                r_frame_tick;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_com;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_swap;
    logic                w_on_phase;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [IDX_W-1:0]    w_idx_next;
    logic                w_lz_blank;
    logic [7:0]          w_seg_next;
    logic [DIGITS-1:0]   w_com_next;
    logic                w_unused;

    // The decoder's DP bit is replaced by our own dp buffer.
    assign w_unused = dec_seg[7];

    // Slot/frame boundary decode and prescaler/index next-state.
    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_frame_end = w_slot_end && (r_idx == IDX_LAST);
        w_swap      = w_frame_end && r_upd_pend;
        w_on_phase  = (r_cnt >= CNT_DEAD);
        if (w_slot_end) begin
            w_cnt_next = CNT_ZERO;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
        if (!w_slot_end) begin
            w_idx_next = r_idx;
        end else if (r_idx == IDX_LAST) begin
            w_idx_next = IDX_ZERO;
        end else begin
            w_idx_next = r_idx + IDX_ONE;
        end
    end

    // Current digit nibble handed to the external decoder.
    always_comb begin
        dec_num = r_disp[{r_idx, 2'b00} +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k>0 is blanked when it and every more-significant nibble are zero.
    always_comb begin
        logic w_acc;
        w_acc      = 1'b1;
        w_lz_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_acc      = w_acc & (r_disp[4*k +: 4] == 4'h0);
            w_lz_blank = w_lz_blank | ((r_idx == IDX_W'(k)) & w_acc);
        end
    end
`else
    // Every digit shows its nibble, zeros included.
    always_comb begin
        w_lz_blank = 1'b0;
    end
`endif

    // Next values for the registered pad outputs.
    always_comb begin
        if (w_on_phase) begin
            w_com_next = ~(COM_ONE << r_idx);
        end else begin
            w_com_next = COM_OFF;
        end
        if (blank || w_lz_blank) begin
            w_seg_next = 8'hFF;
        end else begin
            w_seg_next = {~r_dp[r_idx], dec_seg[6:0]};
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_ZERO;
            r_idx <= IDX_ZERO;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

    // Double buffer: writes land in the shadow, which swaps in only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= {(4*DIGITS){1'b0}};
            r_dp        <= {DIGITS{1'b0}};
            r_shadow    <= {(4*DIGITS){1'b0}};
            r_shadow_dp <= {DIGITS{1'b0}};
            r_upd_pend  <= 1'b0;
        end else begin
            if (w_swap) begin
                r_disp <= r_shadow;
                r_dp   <= r_shadow_dp;
            end
            if (wr_en) begin
                r_shadow    <= wr_data;
                r_shadow_dp <= wr_dp;
                r_upd_pend  <= 1'b1;
            end else if (w_swap) begin
                r_upd_pend  <= 1'b0;
            end
        end
    end

    // Registered segment bus, commons and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= 8'hFF;
            r_com        <= COM_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_com        <= w_com_next;
            r_frame_tick <= w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign com        = r_com;
    assign upd_pend   = r_upd_pend;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl (DIGITS=4, CLK_DIV=4, DEAD=1).
// Expected values follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_led_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        blank;
    logic [3:0]  dec_num;
    logic [7:0]  dec_seg;
    logic [7:0]  seg;
    logic [3:0]  com;
    logic        upd_pend;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_ZERO = 8'hFF;
    localparam logic [7:0] LZ_DP0  = 8'hFF;
`else
    localparam logic [7:0] LZ_ZERO = 8'hC0;
    localparam logic [7:0] LZ_DP0  = 8'h40;
`endif

    led_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .DEAD(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .blank     (blank),
        .dec_num   (dec_num),
        .dec_seg   (dec_seg),
        .seg       (seg),
        .com       (com),
        .upd_pend  (upd_pend),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External hex decoder; bit 7 driven low so the DUT must ignore it.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
            4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
            4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
            4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; default: c = 8'h8E;
        endcase
        return c[6:0];
    endfunction

    assign dec_seg = {1'b0, hex7(dec_num)};

    task automatic wait_digit(input int k, output bit ok);
        logic [3:0] pat;
        pat = 4'b0001 << k;
        pat = ~pat;
        ok  = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (com === pat) ok = 1'b1;
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] dp);
        wr_data = d;
        wr_dp   = dp;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (com !== 4'hF || seg !== 8'hFF || upd_pend !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_values com=%h seg=%h upd=%b ft=%b required F/FF/0/0", com, seg, upd_pend, frame_tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (com !== 4'hF) begin
            errors++;
            $display("FAIL reset_first_dead com=%b required 1111", com);
        end
        @(negedge clk);
        checks++;
        if (com !== 4'b1110) begin
            errors++;
            $display("FAIL reset_digit0_latency com=%b required 1110", com);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (com !== 4'b1111) begin
            errors++;
            $display("FAIL dead_gap com=%b required 1111", com);
        end
        @(negedge clk);
        checks++;
        if (com !== 4'b1101) begin
            errors++;
            $display("FAIL digit1_start com=%b required 1101", com);
        end
    endtask

    task automatic test_write_midframe;
        bit ok;
        logic [7:0] exp [4];
        exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        wait_digit(1, ok);
        do_write(16'h1234, 4'b0000);
        checks++;
        if (!ok || upd_pend !== 1'b1) begin
            errors++;
            $display("FAIL write_pend ok=%b upd=%b required 1", ok, upd_pend);
        end
        for (int k = 2; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== LZ_ZERO) begin
                errors++;
                $display("FAIL no_tear d%0d ok=%b seg=%h required %h", k, ok, seg, LZ_ZERO);
            end
        end
        wait_frame(ok);
        checks++;
        if (!ok || upd_pend !== 1'b0) begin
            errors++;
            $display("FAIL swap_clears_pend ok=%b upd=%b required 0", ok, upd_pend);
        end
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL frame_tick_pulse ft=%b required 0", frame_tick);
        end
        for (int k = 0; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== exp[k]) begin
                errors++;
                $display("FAIL show_1234 d%0d ok=%b seg=%h required %h", k, ok, seg, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_digit(1, ok);
        do_write(16'h1111, 4'b0000);
        do_write(16'h2222, 4'b0000);
        wait_digit(3, ok);
        @(negedge clk);
        do_write(16'h3333, 4'b0000);
        checks++;
        if (!ok || frame_tick !== 1'b1 || upd_pend !== 1'b1) begin
            errors++;
            $display("FAIL coincident_write ok=%b ft=%b upd=%b required 1/1", ok, frame_tick, upd_pend);
        end
        for (int k = 0; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== 8'hA4) begin
                errors++;
                $display("FAIL last_write_wins d%0d ok=%b seg=%h required a4", k, ok, seg);
            end
        end
        wait_frame(ok);
        checks++;
        if (!ok || upd_pend !== 1'b0) begin
            errors++;
            $display("FAIL second_swap ok=%b upd=%b required 0", ok, upd_pend);
        end
        for (int k = 0; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== 8'hB0) begin
                errors++;
                $display("FAIL frame2_3333 d%0d ok=%b seg=%h required b0", k, ok, seg);
            end
        end
    endtask

    task automatic test_dp_blank;
        bit ok;
        logic [7:0] exp [4];
        exp = '{8'hC0, LZ_ZERO, LZ_DP0, LZ_ZERO};
        wait_digit(1, ok);
        do_write(16'h0000, 4'b0100);
        wait_frame(ok);
        for (int k = 0; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== exp[k]) begin
                errors++;
                $display("FAIL dp d%0d ok=%b seg=%h required %h", k, ok, seg, exp[k]);
            end
        end
        blank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== 8'hFF) begin
                errors++;
                $display("FAIL blank d%0d ok=%b seg=%h required ff", k, ok, seg);
            end
        end
        blank = 1'b0;
    endtask

    task automatic test_leading_zero;
        bit ok;
        logic [7:0] exp [4];
        exp = '{8'hC0, 8'h92, LZ_ZERO, LZ_ZERO};
        wait_digit(1, ok);
        do_write(16'h0050, 4'b0000);
        wait_frame(ok);
        for (int k = 0; k < 4; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg !== exp[k]) begin
                errors++;
                $display("FAIL lead_zero d%0d ok=%b seg=%h required %h", k, ok, seg, exp[k]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        int n;
        wait_digit(1, ok);
        do_write(16'h7777, 4'b0000);
        wait_digit(2, ok);
        checks++;
        if (!ok || upd_pend !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pend ok=%b upd=%b required 1", ok, upd_pend);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (com !== 4'hF || seg !== 8'hFF || upd_pend !== 1'b0) begin
            errors++;
            $display("FAIL async_reset com=%h seg=%h upd=%b required F/FF/0", com, seg, upd_pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 8 && n == 0; i++) begin
            @(negedge clk);
            if (com !== 4'hF) n = i;
        end
        checks++;
        if (n != 2 || com !== 4'b1110) begin
            errors++;
            $display("FAIL restart_digit0 clocks=%0d com=%b required 2/1110", n, com);
        end
        wait_frame(ok);
        wait_digit(1, ok);
        checks++;
        if (!ok || seg !== LZ_ZERO || upd_pend !== 1'b0) begin
            errors++;
            $display("FAIL pending_lost ok=%b seg=%h upd=%b required %h/0", ok, seg, upd_pend, LZ_ZERO);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        wr_dp   = 4'b0000;
        blank   = 1'b0;
        test_reset();
        test_write_midframe();
        test_back_to_back();
        test_dp_blank();
        test_leading_zero();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
